// File: rtl/aeolus_pkg.sv
// Shared definitions for the Aeolus control unit: opcodes, FSM states and the
// decoded strobe bundle.
package aeolus_pkg;

  localparam int PC_W = 4;
  localparam int IR_W = 4;

  localparam logic [IR_W-1:0] OP_LDA  = 4'h0;
  localparam logic [IR_W-1:0] OP_LDB  = 4'h1;
  localparam logic [IR_W-1:0] OP_LDO  = 4'h2;
  localparam logic [IR_W-1:0] OP_LDSA = 4'h3;
  localparam logic [IR_W-1:0] OP_LDSB = 4'h4;
  localparam logic [IR_W-1:0] OP_LSH  = 4'h5;
  localparam logic [IR_W-1:0] OP_RSH  = 4'h6;
  localparam logic [IR_W-1:0] OP_CLR  = 4'h7;
  localparam logic [IR_W-1:0] OP_SNZA = 4'h8;
  localparam logic [IR_W-1:0] OP_SNZS = 4'h9;
  localparam logic [IR_W-1:0] OP_ADD  = 4'hA;
  localparam logic [IR_W-1:0] OP_SUB  = 4'hB;
  localparam logic [IR_W-1:0] OP_AND  = 4'hC;
  localparam logic [IR_W-1:0] OP_OR   = 4'hD;
  localparam logic [IR_W-1:0] OP_NOR  = 4'hE;
  localparam logic [IR_W-1:0] OP_XOR  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SKIP_NONE = 2'd0,
    SKIP_A    = 2'd1,
    SKIP_S    = 2'd2
  } skip_t;

  typedef struct packed {
    logic load_a;
    logic load_b;
    logic load_o;
    logic load_s;
    logic s_src;
    logic shift_en;
    logic shift_dir;
    logic alu_en;
  } strobe_t;

endpackage

// File: rtl/aeolus_decoder.sv
// Combinational instruction decode: opcode to datapath strobes, skip type and
// an illegal-opcode flag.
module aeolus_decoder
  import aeolus_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output strobe_t         strb,
  output skip_t           skip,
  output logic            illegal
);

  always_comb begin
    strb    = '0;
    skip    = SKIP_NONE;
    illegal = 1'b0;
    case (ir)
      OP_LDA:  strb.load_a = 1'b1;
      OP_LDB:  strb.load_b = 1'b1;
      OP_LDO:  strb.load_o = 1'b1;
      OP_LDSA: strb.load_s = 1'b1;
      OP_LDSB: begin
        strb.load_s = 1'b1;
        strb.s_src  = 1'b1;
      end
      OP_LSH:  strb.shift_en = 1'b1;
      OP_RSH: begin
        strb.shift_en  = 1'b1;
        strb.shift_dir = 1'b1;
      end
      OP_CLR:  ;
      OP_SNZA: skip = SKIP_A;
      OP_SNZS: skip = SKIP_S;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR: strb.alu_en = 1'b1;
      // unreachable with a fully populated 4-bit opcode map; kept for wider IRs
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Aeolus control unit: fetches opcodes from ROM, pulses one datapath strobe per
// instruction and advances the PC with skip, step and end-of-program handling.
//
// state | meaning
// IDLE  | after reset, waiting for startIn
// FETCH | ROM addressed by PC, opcode captured into IR
// EXEC  | one strobe pulses, PC advances (or skips / wraps / stops)
// WAIT  | step mode pause until stepIn or stepModeIn falls
// HALT  | program finished, waiting for startIn
module program_sequencer
  import aeolus_pkg::*;
#(
  parameter int LAST_ADDR = 14,
  parameter bit WRAP      = 1'b0
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            startIn,
  input  logic            stepModeIn,
  input  logic            stepIn,
  output logic [PC_W-1:0] romAddrOut,
  input  logic [IR_W-1:0] romDataIn,
  input  logic            aZeroIn,
  input  logic            sZeroIn,
  output logic            loadAOut,
  output logic            loadBOut,
  output logic            loadOOut,
  output logic            loadSOut,
  output logic            sSrcOut,
  output logic            shiftEnOut,
  output logic            shiftDirOut,
  output logic            aluEnOut,
  output logic [IR_W-1:0] aluOpOut,
  output logic            busyOut,
  output logic            haltOut,
  output logic            illegalOut
);

  localparam logic [PC_W:0] LAST_EXT = (PC_W+1)'(LAST_ADDR);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            s_src_q;

  strobe_t strb;
  skip_t   skip;
  logic    illegal;
  logic    skip_take;
  logic    end_reached;
  logic    exec;
  logic [PC_W:0] nxt;

  aeolus_decoder u_dec (
    .ir      (ir_q),
    .strb    (strb),
    .skip    (skip),
    .illegal (illegal)
  );

  assign exec      = (state_q == ST_EXEC);
  assign skip_take = ((skip == SKIP_A) && !aZeroIn) || ((skip == SKIP_S) && !sZeroIn);
  // one extra bit so a skip past address 15 is seen as end rather than wrapping
  assign nxt         = {1'b0, pc_q} + (skip_take ? (PC_W+1)'(2) : (PC_W+1)'(1));
  assign end_reached = (nxt > LAST_EXT);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      s_src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (exec && strb.load_s) s_src_q <= strb.s_src;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (startIn) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        ir_d    = romDataIn;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (end_reached) begin
          if (WRAP) begin
            pc_d    = '0;
            state_d = stepModeIn ? ST_WAIT : ST_FETCH;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          pc_d    = nxt[PC_W-1:0];
          state_d = stepModeIn ? ST_WAIT : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (stepIn || !stepModeIn) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    romAddrOut  = pc_q;
    loadAOut    = exec & strb.load_a;
    loadBOut    = exec & strb.load_b;
    loadOOut    = exec & strb.load_o;
    loadSOut    = exec & strb.load_s;
    sSrcOut     = (exec && strb.load_s) ? strb.s_src : s_src_q;
    shiftEnOut  = exec & strb.shift_en;
    shiftDirOut = exec & strb.shift_en & strb.shift_dir;
    aluEnOut    = exec & strb.alu_en;
    aluOpOut    = (exec && strb.alu_en) ? ir_q : '0;
    busyOut     = (state_q == ST_FETCH) || exec || (state_q == ST_WAIT);
    haltOut     = (state_q == ST_HALT);
    illegalOut  = exec & illegal;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: run, skip, end-of-program, step mode,
// wrap mode and asynchronous reset.
module tb_program_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN, start, step_mode, step, a_zero, s_zero;
  logic [3:0] rom_addr, rom_data;
  logic       load_a, load_b, load_o, load_s, s_src, shift_en, shift_dir, alu_en;
  logic [3:0] alu_op;
  logic       busy, halt, illegal;
  logic [3:0] rom [16];

  logic       w_start;
  logic [3:0] w_addr, w_data, w_alu_op;
  logic       w_load_a, w_load_b, w_load_o, w_load_s, w_s_src, w_shift_en, w_shift_dir;
  logic       w_alu_en, w_busy, w_halt, w_illegal;

  assign rom_data = rom[rom_addr];
  assign w_data   = 4'h2;

  program_sequencer dut (
    .clk(clk), .rstN(rstN), .startIn(start), .stepModeIn(step_mode), .stepIn(step),
    .romAddrOut(rom_addr), .romDataIn(rom_data), .aZeroIn(a_zero), .sZeroIn(s_zero),
    .loadAOut(load_a), .loadBOut(load_b), .loadOOut(load_o), .loadSOut(load_s),
    .sSrcOut(s_src), .shiftEnOut(shift_en), .shiftDirOut(shift_dir),
    .aluEnOut(alu_en), .aluOpOut(alu_op), .busyOut(busy), .haltOut(halt),
    .illegalOut(illegal)
  );

  program_sequencer #(.LAST_ADDR(3), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rstN(rstN), .startIn(w_start), .stepModeIn(1'b0), .stepIn(1'b0),
    .romAddrOut(w_addr), .romDataIn(w_data), .aZeroIn(1'b1), .sZeroIn(1'b1),
    .loadAOut(w_load_a), .loadBOut(w_load_b), .loadOOut(w_load_o), .loadSOut(w_load_s),
    .sSrcOut(w_s_src), .shiftEnOut(w_shift_en), .shiftDirOut(w_shift_dir),
    .aluEnOut(w_alu_en), .aluOpOut(w_alu_op), .busyOut(w_busy), .haltOut(w_halt),
    .illegalOut(w_illegal)
  );

  int errors = 0;
  int checks = 0;
  int cap [40];
  int cap_n, busy_n, max_addr;
  bit timed_out;

  // strobe code equals the opcode that should have produced it; 99 = several at once
  function automatic int strobe_code();
    int c;
    int n;
    c = -1;
    n = 0;
    if (load_a)   begin c = 0; n++; end
    if (load_b)   begin c = 1; n++; end
    if (load_o)   begin c = 2; n++; end
    if (load_s)   begin c = s_src ? 4 : 3; n++; end
    if (shift_en) begin c = shift_dir ? 6 : 5; n++; end
    if (alu_en)   begin c = int'(alu_op); n++; end
    if (n > 1) c = 99;
    return c;
  endfunction

  task automatic load_rom();
    logic [3:0] prog [15];
    prog = '{4'h0, 4'h1, 4'hA, 4'h2, 4'hB, 4'h2, 4'hF, 4'h2,
             4'h3, 4'h6, 4'h8, 4'h4, 4'h5, 4'h9, 4'h2};
    for (int i = 0; i < 15; i++) rom[i] = prog[i];
    rom[15] = 4'h7;
  endtask

  // leaves the bench at the negedge where the main DUT sits in FETCH of address 0
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_to_halt();
    int code;
    cap_n     = 0;
    busy_n    = 0;
    max_addr  = 0;
    for (int i = 0; i < 80; i++) begin
      if (halt) break;
      if (busy) busy_n++;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      code = strobe_code();
      if (code != -1 && cap_n < 40) begin
        cap[cap_n] = code;
        cap_n++;
      end
      @(negedge clk);
    end
    timed_out = !halt;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    a_zero = 1'b1; s_zero = 1'b1; w_start = 1'b0;
    load_rom();
    #12;
    checks++;
    if ({load_a, load_b, load_o, load_s, s_src, shift_en, shift_dir, alu_en, alu_op,
         busy, halt, illegal, rom_addr} !== 18'h0)
      $display("FAIL reset_outputs: got %h expected 0",
               {load_a, load_b, load_o, load_s, s_src, shift_en, shift_dir, alu_en, alu_op,
                busy, halt, illegal, rom_addr});
    if ({load_a, load_b, load_o, load_s, s_src, shift_en, shift_dir, alu_en, alu_op,
         busy, halt, illegal, rom_addr} !== 18'h0) errors++;
    checks++;
    if ({w_busy, w_halt, w_addr} !== 6'h0) begin
      errors++;
      $display("FAIL reset_wrap_outputs: got %h expected 0", {w_busy, w_halt, w_addr});
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_not_busy: got %b expected 0", busy);
    end
  endtask

  task automatic check_run(input string name, input int exp_seq [], input int exp_busy,
                           input logic [3:0] exp_pc, input logic exp_ssrc);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s_halt: got halt=%b expected 1 within budget", name, halt);
    end
    checks++;
    if (busy_n !== exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_n, exp_busy);
    end
    checks++;
    if (cap_n !== exp_seq.size()) begin
      errors++;
      $display("FAIL %s_strobe_count: got %0d expected %0d", name, cap_n, exp_seq.size());
    end
    for (int i = 0; i < exp_seq.size() && i < cap_n; i++) begin
      checks++;
      if (cap[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL %s_strobe[%0d]: got %0d expected %0d", name, i, cap[i], exp_seq[i]);
      end
    end
    checks++;
    if (rom_addr !== exp_pc) begin
      errors++;
      $display("FAIL %s_final_pc: got %0d expected %0d", name, rom_addr, exp_pc);
    end
    checks++;
    if (s_src !== exp_ssrc) begin
      errors++;
      $display("FAIL %s_ssrc_held: got %b expected %b", name, s_src, exp_ssrc);
    end
  endtask

  task automatic test_run();
    int exp_seq [];
    exp_seq = '{0, 1, 10, 2, 11, 2, 15, 2, 3, 6, 4, 5, 2};
    a_zero = 1'b1; s_zero = 1'b1; step_mode = 1'b0;
    pulse_start();
    run_to_halt();
    check_run("run", exp_seq, 30, 4'd14, 1'b1);
  endtask

  task automatic test_skip_a();
    int exp_seq [];
    exp_seq = '{0, 1, 10, 2, 11, 2, 15, 2, 3, 6, 5, 2};
    a_zero = 1'b0; s_zero = 1'b1;
    pulse_start();
    run_to_halt();
    check_run("skipa", exp_seq, 28, 4'd14, 1'b0);
  endtask

  task automatic test_skip_past_end();
    int exp_seq [];
    exp_seq = '{0, 1, 10, 2, 11, 2, 15, 2, 3, 6, 4, 5};
    a_zero = 1'b1; s_zero = 1'b0;
    pulse_start();
    run_to_halt();
    check_run("skipend", exp_seq, 28, 4'd13, 1'b1);
    checks++;
    if (max_addr !== 13) begin
      errors++;
      $display("FAIL skipend_max_addr: got %0d expected 13", max_addr);
    end
  endtask

  task automatic test_step_mode();
    int n;
    a_zero = 1'b1; s_zero = 1'b1; step_mode = 1'b1;
    pulse_start();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (strobe_code() != -1) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL step_first_count: got %0d expected 1", n);
    end
    checks++;
    if ({busy, rom_addr} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL step_wait_state: got busy=%b addr=%0d expected busy=1 addr=1", busy, rom_addr);
    end
    n = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (strobe_code() != -1) n++;
        @(negedge clk);
      end
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL step_three_pulses: got %0d instructions expected 3", n);
    end
    checks++;
    if ({busy, halt, rom_addr} !== {1'b1, 1'b0, 4'd4}) begin
      errors++;
      $display("FAIL step_pc_after: got busy=%b halt=%b addr=%0d expected 1 0 4", busy, halt, rom_addr);
    end
    step_mode = 1'b0;
    run_to_halt();
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL step_release_halt: got halt=%b expected 1", halt);
    end
  endtask

  task automatic test_wrap();
    int exp_a;
    @(negedge clk);
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_a = (i / 2) % 4;
      checks++;
      if (int'(w_addr) !== exp_a) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, w_addr, exp_a);
      end
      checks++;
      if (w_halt !== 1'b0) begin
        errors++;
        $display("FAIL wrap_halt[%0d]: got %b expected 0", i, w_halt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    a_zero = 1'b1; s_zero = 1'b1; step_mode = 1'b0;
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if ({alu_en, alu_op} !== {1'b1, 4'hA}) begin
      errors++;
      $display("FAIL arst_add_exec: got en=%b op=%h expected 1 a", alu_en, alu_op);
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if ({alu_en, busy, rom_addr} !== 6'h0) begin
      errors++;
      $display("FAIL arst_drop: got en=%b busy=%b addr=%0d expected 0 0 0", alu_en, busy, rom_addr);
    end
    @(negedge clk);
    rstN = 1'b1;
    pulse_start();
    checks++;
    if ({busy, rom_addr} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL arst_restart_fetch: got busy=%b addr=%0d expected 1 0", busy, rom_addr);
    end
    @(negedge clk);
    checks++;
    if (load_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_restart_lda: got %b expected 1", load_a);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_skip_a();
    test_skip_past_end();
    test_step_mode();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
